// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one external bus port between the instruction
// fetch port (read-only) and the data port (read/write). Data wins by default;
// a starvation counter forces an instruction grant after STARVE_LIMIT
// consecutive data grants taken while a fetch is waiting.
module memory_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    // Instruction port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_busy,
    // Data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_busy,
    // System bus
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] LimitC = CntW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StIdle,
        StGntI,
        StGntD
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

    // Next-state arbitration; the completing requester is never re-granted
    // directly, it goes back through IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (d_req && (!i_req || (starve_cnt_q < LimitC))) begin
                    state_d = StGntD;
                end else if (i_req) begin
                    state_d = StGntI;
                end
            end
            StGntI: begin
                if (m_ack) state_d = d_req ? StGntD : StIdle;
            end
            StGntD: begin
                if (m_ack) state_d = i_req ? StGntI : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Starvation counter: counts data-grant entries while a fetch waits,
    // cleared whenever the fetch port is granted.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if ((state_d == StGntI) && (state_q != StGntI)) begin
            starve_cnt_d = '0;
        end else if ((state_d == StGntD) && (state_q != StGntD) && i_req &&
                     (starve_cnt_q != LimitC)) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Bus field mux and requester stall/read-data outputs; m_req comes only
    // from the registered state so m_ack never reaches it combinationally.
    always_comb begin
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
        i_rdata = '0;
        d_rdata = '0;
        i_busy  = i_req;
        d_busy  = d_req;
        unique case (state_q)
            StGntI: begin
                m_req   = 1'b1;
                m_addr  = i_addr;
                m_be    = 4'hF;
                i_rdata = m_rdata;
                i_busy  = i_req & ~m_ack;
            end
            StGntD: begin
                m_req   = 1'b1;
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                m_be    = d_be;
                d_rdata = m_rdata;
                d_busy  = d_req & ~m_ack;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: a per-cycle vector table covering
// reset, lone fetch, spurious ack, waited write and contention, followed by
// hand sequences for reset mid-transfer and the starvation limit.
module tb_memory_port_arbiter;

    localparam int unsigned Limit = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_be;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_busy, d_busy, m_req, m_we;
    logic [3:0]  m_be;

    int checks = 0;
    int errors = 0;

    memory_port_arbiter #(.STARVE_LIMIT(Limit)) dut (
        .clk    (clk),
        .reset  (reset),
        .i_req  (i_req),
        .i_addr (i_addr),
        .i_rdata(i_rdata),
        .i_busy (i_busy),
        .d_req  (d_req),
        .d_we   (d_we),
        .d_addr (d_addr),
        .d_wdata(d_wdata),
        .d_be   (d_be),
        .d_rdata(d_rdata),
        .d_busy (d_busy),
        .m_req  (m_req),
        .m_we   (m_we),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_be   (m_be),
        .m_rdata(m_rdata),
        .m_ack  (m_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        logic [31:0] m_rdata;
        logic        m_ack;
    } in_t;

    typedef struct packed {
        logic        m_req;
        logic        m_we;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic [3:0]  m_be;
        logic [31:0] i_rdata;
        logic [31:0] d_rdata;
        logic        i_busy;
        logic        d_busy;
    } exp_t;

    localparam int NumVec = 24;
    in_t  vin  [NumVec];
    exp_t vexp [NumVec];

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic drive(input in_t v);
        reset   = v.rst;
        i_req   = v.i_req;
        i_addr  = v.i_addr;
        d_req   = v.d_req;
        d_we    = v.d_we;
        d_addr  = v.d_addr;
        d_wdata = v.d_wdata;
        d_be    = v.d_be;
        m_rdata = v.m_rdata;
        m_ack   = v.m_ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [135:0] outs();
        return {m_req, m_we, m_addr, m_wdata, m_be, i_rdata, d_rdata, i_busy, d_busy};
    endfunction

    localparam logic [31:0] AI = 32'hBFC0_0000;
    localparam logic [31:0] RI = 32'h2408_0001;
    localparam logic [31:0] AD = 32'h8000_0010;
    localparam logic [31:0] WD = 32'hDEAD_BEEF;
    localparam logic [31:0] CF = 32'h0000_CAFE;

    initial begin
        // Reset, spurious ack, lone fetch
        vin[0]  = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1234, 1'b1};
        vexp[0] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1};
        vin[1]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h55, 1'b1};
        vexp[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        vin[2]  = '{1'b1, 1'b1, AI, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0};
        vexp[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0};
        vin[3]  = '{1'b1, 1'b1, AI, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, RI, 1'b1};
        vexp[3] = '{1'b1, 1'b0, AI, 32'h0, 4'hF, RI, 32'h0, 1'b0, 1'b0};
        vin[4]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1};
        vexp[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        // Spurious ack with a fetch pending in IDLE, then a one-wait fetch
        vin[5]  = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hAAAA, 1'b1};
        vexp[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0};
        vin[6]  = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hAAAA, 1'b0};
        vexp[6] = '{1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 32'hAAAA, 32'h0, 1'b1, 1'b0};
        vin[7]  = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h77, 1'b1};
        vexp[7] = '{1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 32'h77, 32'h0, 1'b0, 1'b0};
        // Data write with three wait states
        vin[8]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, AD, WD, 4'h3, 32'h11, 1'b0};
        vexp[8] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1};
        for (int k = 9; k <= 11; k++) begin
            vin[k]  = vin[8];
            vexp[k] = '{1'b1, 1'b1, AD, WD, 4'h3, 32'h0, 32'h11, 1'b0, 1'b1};
        end
        vin[12]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, AD, WD, 4'h3, 32'h11, 1'b1};
        vexp[12] = '{1'b1, 1'b1, AD, WD, 4'h3, 32'h0, 32'h11, 1'b0, 1'b0};
        vin[13]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0};
        vexp[13] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        // Contention on a zero-wait bus: D, I, D, I, D
        vin[14]  = '{1'b1, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, CF, 1'b1};
        vexp[14] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1};
        vin[15]  = vin[14];
        vexp[15] = '{1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 32'h0, CF, 1'b1, 1'b0};
        vin[16]  = vin[14];
        vexp[16] = '{1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, CF, 32'h0, 1'b0, 1'b1};
        vin[17]  = vin[14];
        vexp[17] = vexp[15];
        vin[18]  = vin[14];
        vexp[18] = vexp[16];
        vin[19]  = '{1'b1, 1'b0, 32'h1000, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, CF, 1'b1};
        vexp[19] = '{1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 32'h0, CF, 1'b0, 1'b0};
        // Same requester again pays an IDLE cycle, then drops req while granted
        vin[20]  = vin[19];
        vexp[20] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1};
        vin[21]  = '{1'b1, 1'b0, 32'h1000, 1'b0, 1'b0, 32'h2000, 32'h0, 4'hF, CF, 1'b0};
        vexp[21] = '{1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 32'h0, CF, 1'b0, 1'b0};
        vin[22]  = '{1'b1, 1'b0, 32'h1000, 1'b0, 1'b0, 32'h2000, 32'h0, 4'hF, CF, 1'b1};
        vexp[22] = vexp[21];
        vin[23]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0};
        vexp[23] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};

        drive('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0});
        tick();

        for (int i = 0; i < NumVec; i++) begin
            drive(vin[i]);
            #1;
            chk($sformatf("vec%0d", i), outs(), vexp[i]);
            tick();
        end

        // Reset mid-transfer: enter GNT_D, assert reset without ack
        drive('{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 32'h0, 1'b0});
        tick();
        chk("rst_pre_mreq", 136'(m_req), 136'(1));
        chk("rst_pre_addr", 136'(m_addr), 136'(32'h3000));
        reset = 1'b0;
        #1;
        chk("rst_sync_hold", 136'(m_req), 136'(1));
        tick();
        chk("rst_mreq", 136'(m_req), 136'(0));
        chk("rst_dbusy", 136'(d_busy), 136'(1));
        chk("rst_cnt", 136'(dut.starve_cnt_q), 136'(0));
        reset = 1'b1;
        #1;
        chk("rst_rel_idle", 136'(m_req), 136'(0));
        tick();
        chk("rst_regrant", 136'({m_req, m_addr}), 136'({1'b1, 32'h3000}));
        m_ack = 1'b1;
        #1;
        chk("rst_done_busy", 136'(d_busy), 136'(0));
        tick();
        d_req = 1'b0;
        m_ack = 1'b0;
        tick();

        // Starvation limit 2: two D grants with a fetch waiting, then I
        i_req  = 1'b1;
        i_addr = 32'h4000;
        d_req  = 1'b1;
        d_addr = 32'h5000;
        #1;
        chk("stv_idle", 136'(m_req), 136'(0));
        tick();
        chk("stv_d1", 136'({m_addr, dut.starve_cnt_q}), 136'({32'h5000, 2'd1}));
        m_ack = 1'b1;
        i_req = 1'b0;
        tick();
        m_ack = 1'b0;
        i_req = 1'b1;
        #1;
        chk("stv_gap", 136'(m_req), 136'(0));
        tick();
        chk("stv_d2", 136'({m_addr, dut.starve_cnt_q}), 136'({32'h5000, 2'd2}));
        m_ack = 1'b1;
        i_req = 1'b0;
        tick();
        m_ack = 1'b0;
        i_req = 1'b1;
        tick();
        chk("stv_i", 136'({m_req, m_addr, dut.starve_cnt_q}), 136'({1'b1, 32'h4000, 2'd0}));
        chk("stv_i_busy", 136'({i_busy, d_busy}), 136'({1'b1, 1'b1}));
        m_ack = 1'b1;
        #1;
        chk("stv_i_done", 136'({i_busy, d_busy}), 136'({1'b0, 1'b1}));
        tick();
        chk("stv_d3", 136'({m_addr, dut.starve_cnt_q}), 136'({32'h5000, 2'd1}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares one external memory port between the fetch-stage instruction port (read-only) and the memory-stage data port (read/write). Sits between the core's two memory interfaces and the single system bus. It exposes per-requester `busy` stall signals that plug directly into the pipeline flow controller's `instruction_memory_busy` and `data_memory_busy` inputs. Data accesses have priority by default, and a starvation counter guarantees forward progress for instruction fetch.

## Interface

**Parameters**
- `STARVE_LIMIT`, default 4: maximum consecutive data grants issued while `i_req` is pending. Legal range is ≥1.

**Ports**
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: one clock; reset is synchronous and active-low (`reset`=0 resets on the rising edge).
- `i_req` in 1: instruction read request.
- `i_addr` in 32: instruction address.
- `i_rdata` out 32: instruction read data.
- `i_busy` out 1: instruction port stall.
- `d_req` in 1: data request.
- `d_we` in 1: data write enable.
- `d_addr` in 32: data address.
- `d_wdata` in 32: data write data.
- `d_be` in 4: data byte enables.
- `d_rdata` out 32: data read data.
- `d_busy` out 1: data port stall.
- `m_req` out 1: bus request.
- `m_we` out 1: bus write.
- `m_addr` out 32: bus address.
- `m_wdata` out 32: bus write data.
- `m_be` out 4: bus byte enables.
- `m_rdata` in 32: bus read data.
- `m_ack` in 1: bus transfer complete; valid only while `m_req`=1.

## Operation

**Requester protocol**
- A requester raises `req` with its fields.
- It holds `req` and all fields stable while its `busy`=1.
- The transaction completes in the cycle its `busy`=0 with `req`=1. Read data is valid in that cycle only.
- `req` still high in the following cycle is a new transaction.

**FSM states:** IDLE, GNT_I, GNT_D.

**IDLE**
- `m_req`=0.
- If `d_req`=1 and (`i_req`=0 or `starve_cnt`<`STARVE_LIMIT`), go to GNT_D.
- Otherwise, if `i_req`=1, go to GNT_I.
- Otherwise, stay in IDLE.

**GNT_I**
- `m_req`=1, `m_we`=0, `m_addr`=`i_addr`, `m_be`=4'hF, `m_wdata`=0.
- On `m_ack`: go to GNT_D if `d_req`=1, else to IDLE.

**GNT_D**
- `m_req`=1, `m_we`=`d_we`, `m_addr`=`d_addr`, `m_wdata`=`d_wdata`, `m_be`=`d_be`.
- On `m_ack`: go to GNT_I if `i_req`=1, else to IDLE.
- The completing requester's own `req` is never considered at completion; it re-arbitrates via IDLE.

**Starvation counter (`starve_cnt`)**
- Width is clog2(`STARVE_LIMIT`+1).
- Increments, saturating, on every entry into GNT_D while `i_req`=1.
- Clears on every entry into GNT_I.

**Output and bus-field rules**
- `i_busy` = `i_req` & ~(state==GNT_I & `m_ack`).
- `d_busy` = `d_req` & ~(state==GNT_D & `m_ack`).
- `i_rdata` = `m_rdata` when state==GNT_I, else 0. `d_rdata` = `m_rdata` when state==GNT_D, else 0.
- All `m_*` fields are combinational muxes of the granted requester. They are 0 in IDLE.
- `m_we` is gated by `m_req`.

**Boundary conditions**
- `m_ack` while `m_req`=0 is ignored.
- A requester dropping `req` while granted is a protocol violation. The FSM still completes on `m_ack`.
- Simultaneous `i_req` and `d_req` in IDLE resolves by the starvation rule above.
- Reset mid-transaction: state goes to IDLE and `starve_cnt` to 0 on that edge. The in-flight bus transfer is abandoned, and the bus must tolerate `m_req` dropping.

## Timing

**Reset values**
- State is IDLE and `starve_cnt`=0.
- `m_req`, `m_we`, `m_addr`, `m_wdata`, `m_be`, `i_rdata`, `d_rdata` are all 0.
- `i_busy`=`i_req` and `d_busy`=`d_req`.

**Latency**
- `req` rising at cycle N in IDLE gives a grant at N+1.
- With a zero-wait bus (`m_ack` at N+1), `busy` is 1 at N and 0 at N+1: one stall cycle per access.
- Back-to-back cross-grant: the other requester completes at the earliest one cycle after the first completion.
- The same requester re-requesting pays one IDLE cycle.
- No combinational path from `m_ack` to `m_req`.
- The paths from `m_ack` to `busy`/`rdata` are combinational.

## Test plan

1. **Lone fetch:** `i_req`=1 with `i_addr`=0xBFC00000, `m_ack` on the first `m_req` cycle, `m_rdata`=0x24080001. Required: `m_addr`=0xBFC00000, `m_we`=0, `i_busy` 1→0 after one cycle, `i_rdata`=0x24080001 in the completion cycle.
2. **Contention:** `i_req`=`d_req`=1 both held, zero-wait bus. Required grant order is D,I,D,I… with cross-grant back-to-back. Each port completes once per two bus cycles plus IDLE cycles.
3. **Starvation:** `STARVE_LIMIT`=2, `d_req` re-issued continuously, `i_req` held. Required: at most 2 consecutive D grants, then an I grant, after which `starve_cnt` returns to 0.
4. **Data write with wait states:** `d_we`=1, `d_addr`=0x80000010, `d_wdata`=0xDEADBEEF, `d_be`=4'b0011, `m_ack` after 3 wait cycles. Required: fields stable on the bus for 4 cycles and `d_busy`=1 until the ack cycle.
5. **Reset mid-transfer:** `reset`=0 while in GNT_D with no ack. Required: next cycle `m_req`=0, state IDLE, `d_busy`=`d_req`. After release, the request is re-granted.
6. **Spurious ack:** `m_ack`=1 in IDLE. Required: no state change and `busy` unaffected.
